pe24_seq: RTL

- Sequencer for one 24-lane pattern-matching PE array built from three chained pe8 stages.
- Stores a pattern of up to PAT_DEPTH entries. Accepts one 24-character text window per run.
- Per run: clears the array, issues one pattern entry per cycle with the control/flag signals, waits the array latency, then returns the 24-bit match vector and carry bits through a valid/ready result port.
- Sits between the host/stream front-end and the PE array instance.

---
 rtl/pe24_seq_pkg.sv | 25 ++
 rtl/pe24_seq_pat_mem.sv | 23 ++
 rtl/pe24_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pe24_seq_pkg.sv
// rtl/pe24_seq_pkg.sv - shared constants and state encoding for the pe24 sequencer
package pe24_seq_pkg;

    localparam int LANES    = 24;
    localparam int CHAR_W   = 8;
    localparam int KEY_W    = 10;
    localparam int MASK_BIT = 10;
    localparam int GAP_BIT  = 11;
    localparam int ENTRY_W  = 12;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_CLEAR  = S_CLEAR,
        ST_ISSUE  = S_ISSUE,
        ST_DRAIN  = S_DRAIN,
        ST_RESULT = S_RESULT
    } state_t;

endpackage

// File: rtl/pe24_seq_pat_mem.sv
// rtl/pe24_seq_pat_mem.sv - pattern register file, one write port, async read, no reset
module pe24_seq_pat_mem
    import pe24_seq_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe24_seq.sv
// rtl/pe24_seq.sv - run sequencer feeding pattern entries to a 24-lane PE array
module pe24_seq
    import pe24_seq_pkg::*;
#(
    parameter int PAT_DEPTH = 16,
    parameter int AW        = 4,
    parameter int PE_LAT    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pat_we,
    input  logic [AW-1:0]             pat_waddr,
    input  logic [ENTRY_W-1:0]        pat_wdata,
    input  logic [AW:0]               pat_len,
    input  logic [LANES-1:0]          overlap_cfg,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [LANES*CHAR_W-1:0]   s_text,
    input  logic [4:0]                s_nchar,
    output logic                      pe_clr,
    output logic [LANES*CHAR_W-1:0]   pe_text,
    output logic [KEY_W-1:0]          pe_key,
    output logic                      pe_is_gap,
    output logic                      pe_is_mask,
    output logic                      pe_firstmatch,
    output logic                      pe_is_firstgap,
    output logic [LANES-1:0]          pe_ctrl,
    output logic [LANES-1:0]          pe_overlap,
    output logic                      pe_r0_lin,
    output logic                      pe_r1_lin,
    output logic                      pe_r2_lin,
    input  logic [LANES-1:0]          pe_win_out,
    input  logic                      pe_r0_out,
    input  logic                      pe_r1_out,
    input  logic                      pe_r2_out,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [LANES-1:0]          m_match,
    output logic [2:0]                m_carry,
    output logic                      m_any,
    output logic                      busy
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(PAT_DEPTH);

    state_t             state;
    logic [AW:0]        len_q;
    logic [AW:0]        idx;
    logic [LANES-1:0]   ctrl_q;
    logic [2:0]         dcnt;
    logic [ENTRY_W-1:0] rdata;
    logic [4:0]         nch;
    logic [LANES-1:0]   ctrl_n;
    logic [AW:0]        len_n;

    always_comb begin
        nch   = (s_nchar > 5'd24) ? 5'd24 : s_nchar;
        len_n = (pat_len > DEPTH_V) ? DEPTH_V : pat_len;
        for (int i = 0; i < LANES; i++) ctrl_n[i] = (5'(i) < nch);
    end

    assign s_ready   = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign pe_r0_lin = 1'b0;
    assign pe_r1_lin = 1'b0;
    assign pe_r2_lin = 1'b0;

    pe24_seq_pat_mem #(.AW(AW)) u_pat_mem (
        .clk   (clk),
        .we    (pat_we && (state == ST_IDLE)),
        .waddr (pat_waddr),
        .wdata (pat_wdata),
        .raddr (idx[AW-1:0]),
        .rdata (rdata)
    );

    // idx always points at the next entry to issue, so the async read is ready one edge ahead
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            len_q          <= '0;
            idx            <= '0;
            ctrl_q         <= '0;
            dcnt           <= '0;
            pe_clr         <= 1'b0;
            pe_text        <= '0;
            pe_key         <= '0;
            pe_is_gap      <= 1'b0;
            pe_is_mask     <= 1'b0;
            pe_firstmatch  <= 1'b0;
            pe_is_firstgap <= 1'b0;
            pe_ctrl        <= '0;
            pe_overlap     <= '0;
            m_valid        <= 1'b0;
            m_match        <= '0;
            m_carry        <= '0;
            m_any          <= 1'b0;
        end else begin
            pe_clr <= 1'b0;
            case (state)
                ST_IDLE: if (s_valid) begin
                    pe_text    <= s_text;
                    pe_overlap <= overlap_cfg;
                    len_q      <= len_n;
                    ctrl_q     <= ctrl_n;
                    idx        <= '0;
                    pe_clr     <= 1'b1;
                    state      <= ST_CLEAR;
                end
                ST_CLEAR: if (len_q != '0) begin
                    pe_key         <= rdata[KEY_W-1:0];
                    pe_is_gap      <= rdata[GAP_BIT];
                    pe_is_mask     <= rdata[MASK_BIT];
                    pe_firstmatch  <= 1'b1;
                    pe_is_firstgap <= rdata[GAP_BIT];
                    pe_ctrl        <= ctrl_q;
                    idx            <= idx + (AW+1)'(1);
                    state          <= ST_ISSUE;
                end else begin
                    m_match <= '0;
                    m_carry <= '0;
                    m_any   <= 1'b0;
                    m_valid <= 1'b1;
                    state   <= ST_RESULT;
                end
                ST_ISSUE: begin
                    pe_firstmatch <= 1'b0;
                    if (idx == len_q) begin
                        pe_key         <= '0;
                        pe_is_gap      <= 1'b0;
                        pe_is_mask     <= 1'b0;
                        pe_is_firstgap <= 1'b0;
                        dcnt           <= 3'(PE_LAT - 1);
                        state          <= ST_DRAIN;
                    end else begin
                        pe_key     <= rdata[KEY_W-1:0];
                        pe_is_gap  <= rdata[GAP_BIT];
                        pe_is_mask <= rdata[MASK_BIT];
                        idx        <= idx + (AW+1)'(1);
                    end
                end
                ST_DRAIN: if (dcnt == 3'd0) begin
                    m_match <= pe_win_out;
                    m_carry <= {pe_r2_out, pe_r1_out, pe_r0_out};
                    m_any   <= |pe_win_out;
                    m_valid <= 1'b1;
                    pe_ctrl <= '0;
                    state   <= ST_RESULT;
                end else begin
                    dcnt <= dcnt - 3'd1;
                end
                ST_RESULT: if (m_ready) begin
                    m_valid <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
